dma_job_scheduler: RTL and testbench

//  Front-end controller for the single-channel dma engine. Holds per-requester job queues
//  (rd_addr, wr_addr, len in cache lines) and round-robin arbitrates among them. Launches
//  one job at a time via the engine's begin_again restart and waits for its finished flag.

---
 rtl/dma_job_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_dma_job_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_job_scheduler.sv
// Job front-end for a single-channel DMA engine: per-requester job FIFOs, round-robin
// pick, one engine job in flight, completion report with status and cycle count.
module dma_job_scheduler #(
    parameter int N_CHAN  = 4,
    parameter int QDEPTH  = 4,
    parameter int ADDR_W  = 42,
    parameter int LEN_W   = 32,
    parameter int TIMEOUT = 2**20
) (
    input  logic                      clk,
    input  logic                      soft_reset,
    input  logic [N_CHAN-1:0]         req_valid,
    output logic [N_CHAN-1:0]         req_ready,
    input  logic [N_CHAN*ADDR_W-1:0]  req_rd_addr,
    input  logic [N_CHAN*ADDR_W-1:0]  req_wr_addr,
    input  logic [N_CHAN*LEN_W-1:0]   req_len,
    output logic                      eng_start,
    output logic [ADDR_W-1:0]         eng_rd_addr,
    output logic [ADDR_W-1:0]         eng_wr_addr,
    output logic [LEN_W-1:0]          eng_len,
    input  logic                      eng_finished,
    output logic                      done_valid,
    output logic [$clog2(N_CHAN)-1:0] done_chan,
    output logic [1:0]                done_err,
    output logic [31:0]               done_cycles,
    output logic                      busy
);
    localparam int          CW  = $clog2(N_CHAN);
    localparam int          PW  = $clog2(QDEPTH);
    localparam logic [31:0] TMO = 32'(TIMEOUT);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ADDR    = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] wr;
        logic [LEN_W-1:0]  len;
    } job_t;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_CLR, S_RUN, S_DONE} state_t;

    job_t          job_in [N_CHAN];
    job_t          mem    [N_CHAN][QDEPTH];
    logic [PW:0]   wptr   [N_CHAN];
    logic [PW:0]   rptr   [N_CHAN];
    logic [N_CHAN-1:0] full, empty, push;
    logic [CW-1:0] rr_ptr, sel, chan_q;
    logic          found, pending, pop, timeout_hit;
    int            idx;
    job_t          head, job_q;
    state_t        state, state_nxt;
    logic [1:0]    err_q, err_nxt;
    logic [31:0]   cnt, cnt_inc;

    always_comb begin
        for (int i = 0; i < N_CHAN; i++) begin
            job_in[i].rd  = req_rd_addr[i*ADDR_W +: ADDR_W];
            job_in[i].wr  = req_wr_addr[i*ADDR_W +: ADDR_W];
            job_in[i].len = req_len[i*LEN_W +: LEN_W];
            empty[i] = (wptr[i] == rptr[i]);
            full[i]  = (wptr[i][PW] != rptr[i][PW]) && (wptr[i][PW-1:0] == rptr[i][PW-1:0]);
        end
    end

    assign req_ready = ~full & {N_CHAN{~soft_reset}};
    assign push      = req_valid & req_ready;
    assign pending   = |(~empty);

    // First non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_CHAN; k++) begin
            idx = (int'(rr_ptr) + k) % N_CHAN;
            if (!found && !empty[idx]) begin
                sel   = CW'(idx);
                found = 1'b1;
            end
        end
    end

    assign head = mem[sel][rptr[sel][PW-1:0]];
    assign pop  = (state == S_IDLE) && pending;

    always_ff @(posedge clk) begin
        if (soft_reset) begin
            for (int i = 0; i < N_CHAN; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (push[i]) wptr[i] <= wptr[i] + 1'b1;
                if (pop && sel == CW'(i)) rptr[i] <= rptr[i] + 1'b1;
            end
        end
    end

    // NOTE: payload storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CHAN; i++) begin
            if (push[i]) mem[i][wptr[i][PW-1:0]] <= job_in[i];
        end
    end

    assign cnt_inc     = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    assign timeout_hit = (cnt_inc >= TMO);

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        unique case (state)
            S_IDLE: begin
                if (pending) begin
                    if (head.len == '0) begin
                        state_nxt = S_DONE;
                        err_nxt   = ERR_OK;
                    end else if (head.rd == '0 || head.wr == '0) begin
                        state_nxt = S_DONE;
                        err_nxt   = ERR_ADDR;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: state_nxt = S_WAIT_CLR;
            S_WAIT_CLR: begin
                // The finished flag may still be high from the previous job.
                if (timeout_hit) begin
                    state_nxt = S_DONE;
                    err_nxt   = ERR_TIMEOUT;
                end else if (!eng_finished) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (eng_finished) begin
                    state_nxt = S_DONE;
                    err_nxt   = ERR_OK;
                end else if (timeout_hit) begin
                    state_nxt = S_DONE;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (soft_reset) begin
            state  <= S_IDLE;
            err_q  <= ERR_OK;
            rr_ptr <= '0;
            chan_q <= '0;
            cnt    <= '0;
            job_q  <= '0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            if (pop) begin
                job_q  <= head;
                chan_q <= sel;
                rr_ptr <= (sel == CW'(N_CHAN - 1)) ? '0 : sel + 1'b1;
                cnt    <= '0;
            end else if (state == S_LOAD || state == S_WAIT_CLR || state == S_RUN) begin
                cnt <= cnt_inc;
            end
        end
    end

    assign eng_start   = (state == S_LOAD) && !soft_reset;
    assign eng_rd_addr = job_q.rd;
    assign eng_wr_addr = job_q.wr;
    assign eng_len     = job_q.len;
    assign done_valid  = (state == S_DONE) && !soft_reset;
    assign done_chan   = chan_q;
    assign done_err    = err_q;
    assign done_cycles = cnt;
    assign busy        = !soft_reset && (state != S_IDLE || pending);

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Bench for dma_job_scheduler: directed scenarios plus random traffic, checked every cycle
// against a job-timeline reference model (queues, round-robin index, predicted cycles).
module tb_dma_job_scheduler;
    localparam int N   = 4;
    localparam int QD  = 4;
    localparam int AW  = 42;
    localparam int LW  = 32;
    localparam int TMO = 64;

    logic              clk = 1'b0;
    logic              soft_reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_rd_addr;
    logic [N*AW-1:0]   req_wr_addr;
    logic [N*LW-1:0]   req_len;
    logic              eng_start;
    logic [AW-1:0]     eng_rd_addr;
    logic [AW-1:0]     eng_wr_addr;
    logic [LW-1:0]     eng_len;
    logic              eng_finished;
    logic              done_valid;
    logic [1:0]        done_chan;
    logic [1:0]        done_err;
    logic [31:0]       done_cycles;
    logic              busy;

    dma_job_scheduler #(.N_CHAN(N), .QDEPTH(QD), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TMO)) dut (
        .clk(clk), .soft_reset(soft_reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd_addr(req_rd_addr), .req_wr_addr(req_wr_addr), .req_len(req_len),
        .eng_start(eng_start), .eng_rd_addr(eng_rd_addr), .eng_wr_addr(eng_wr_addr),
        .eng_len(eng_len), .eng_finished(eng_finished),
        .done_valid(done_valid), .done_chan(done_chan), .done_err(done_err),
        .done_cycles(done_cycles), .busy(busy)
    );

    always #5 clk = ~clk;

    // d: engine finishes d cycles after its start (-1 = never); h: stale flag held h cycles past start.
    typedef struct {
        logic [AW-1:0] rd;
        logic [AW-1:0] wr;
        logic [LW-1:0] len;
        int            d;
        int            h;
    } tjob_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    tjob_t         mq [N][$];
    int            m_rr, m_start_c, m_done_c, m_chan, m_err, m_cyc;
    bit            m_active;
    logic [AW-1:0] m_rd, m_wr;
    logic [LW-1:0] m_len;

    logic          fin;
    int            fin_set_c, fin_clr_c;
    logic          drv_rst;
    logic [N-1:0]  drv_valid;
    tjob_t         drv_job [N];
    logic [N-1:0]  exp_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic tjob_t mk(input logic [AW-1:0] rd, input logic [AW-1:0] wr,
                                 input logic [LW-1:0] len, input int d, input int h);
        tjob_t j;
        j.rd = rd; j.wr = wr; j.len = len; j.d = d; j.h = h;
        return j;
    endfunction

    function automatic tjob_t rand_job();
        tjob_t j;
        j.rd  = ($urandom_range(0, 11) == 0) ? '0 : AW'({$urandom(), $urandom()});
        j.wr  = ($urandom_range(0, 11) == 0) ? '0 : AW'({$urandom(), $urandom()});
        j.len = ($urandom_range(0, 9) == 0) ? '0 : LW'($urandom_range(1, 300));
        j.h   = int'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0:       j.d = -1;
            1:       j.d = TMO - 1;
            default: j.d = j.h + 2 + int'($urandom_range(0, 25));
        endcase
        return j;
    endfunction

    function automatic bit model_pending();
        for (int i = 0; i < N; i++) if (mq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_rr = 0; m_active = 1'b0; m_start_c = -1; m_done_c = -1;
        m_rd = '0; m_wr = '0; m_len = '0;
        fin = 1'b0; fin_set_c = -1; fin_clr_c = -1;
    endtask

    // Job leaves its queue in cycle c; outcome and timing are fixed right here.
    task automatic model_pop(input int c);
        int    sel;
        int    s;
        tjob_t j;
        sel = -1;
        for (int k = 0; k < N; k++) begin
            if (sel < 0 && mq[(m_rr + k) % N].size() > 0) sel = (m_rr + k) % N;
        end
        j = mq[sel].pop_front();
        m_rr = (sel + 1) % N;
        m_rd = j.rd; m_wr = j.wr; m_len = j.len;
        m_chan = sel; m_active = 1'b1; m_start_c = -1;
        if (j.len == '0) begin
            m_done_c = c + 1; m_err = 0; m_cyc = 0;
        end else if (j.rd == '0 || j.wr == '0) begin
            m_done_c = c + 1; m_err = 2; m_cyc = 0;
        end else begin
            s = c + 1;
            m_start_c = s;
            fin_clr_c = s + 1 + j.h;
            fin_set_c = (j.d >= 0) ? s + j.d : -1;
            if (j.d >= 0 && j.d <= TMO - 1) begin
                m_done_c = s + j.d + 1; m_err = 0; m_cyc = j.d + 1;
            end else begin
                m_done_c = s + TMO; m_err = 1; m_cyc = TMO;
            end
        end
    endtask

    task automatic tick();
        bit exp_done;
        if (cyc == fin_clr_c) fin = 1'b0;
        if (cyc == fin_set_c) fin = 1'b1;
        soft_reset   = drv_rst;
        req_valid    = drv_valid;
        eng_finished = fin;
        for (int i = 0; i < N; i++) begin
            req_rd_addr[i*AW +: AW] = drv_job[i].rd;
            req_wr_addr[i*AW +: AW] = drv_job[i].wr;
            req_len[i*LW +: LW]     = drv_job[i].len;
        end
        #1;
        for (int i = 0; i < N; i++) exp_ready[i] = !drv_rst && (mq[i].size() < QD);
        exp_done = !drv_rst && m_active && (m_done_c == cyc);
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("eng_start", 64'(eng_start), 64'(!drv_rst && m_active && m_start_c == cyc));
        check("done_valid", 64'(done_valid), 64'(exp_done));
        check("busy", 64'(busy), 64'(!drv_rst && (m_active || model_pending())));
        if (!drv_rst) begin
            check("eng_rd_addr", 64'(eng_rd_addr), 64'(m_rd));
            check("eng_wr_addr", 64'(eng_wr_addr), 64'(m_wr));
            check("eng_len", 64'(eng_len), 64'(m_len));
        end
        if (exp_done) begin
            check("done_chan", 64'(done_chan), 64'(m_chan));
            check("done_err", 64'(done_err), 64'(m_err));
            check("done_cycles", 64'(done_cycles), 64'(m_cyc));
        end
        if (drv_rst) begin
            model_reset();
        end else begin
            if (m_active) begin
                if (m_done_c == cyc) m_active = 1'b0;
            end else if (model_pending()) begin
                model_pop(cyc);
            end
            for (int i = 0; i < N; i++) if (drv_valid[i] && exp_ready[i]) mq[i].push_back(drv_job[i]);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        drv_valid = '0;
        drv_rst   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic submit(input int ch, input tjob_t j);
        drv_job[ch] = j;
        drv_valid   = N'(1) << ch;
        tick();
        drv_valid   = '0;
    endtask

    initial begin
        int guard;
        drv_rst = 1'b1;
        drv_valid = '0;
        for (int i = 0; i < N; i++) drv_job[i] = mk('0, '0, '0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        repeat (3) tick();
        drv_rst = 1'b0;

        // Single job, engine done 20 cycles after start.
        submit(0, mk(42'h100, 42'h200, 32'd8, 20, 0));
        idle(30);

        // All channels in one cycle; stale finished flag between jobs.
        for (int i = 0; i < N; i++) drv_job[i] = mk(AW'(32'h1000 + i), AW'(32'h2000 + i), LW'(4 + i), 5 + i, 0);
        drv_valid = '1;
        tick();
        idle(120);

        // ch1 fills its queue behind a long ch0 job; ch2 joins once.
        submit(0, mk(42'h300, 42'h400, 32'd16, 40, 1));
        for (int k = 0; k < 5; k++) begin
            drv_job[1] = mk(AW'(32'h500 + k), AW'(32'h600 + k), LW'(k + 1), 8, 0);
            drv_job[2] = mk(42'h700, 42'h800, 32'd3, 7, 0);
            drv_valid  = (k == 0) ? 4'b0110 : 4'b0010;
            tick();
        end
        idle(150);

        // Zero length and zero address jobs.
        submit(3, mk(42'h10, 42'h20, 32'd0, 5, 0));
        submit(2, mk(42'h30, 42'h0, 32'd5, 5, 0));
        idle(10);

        // Engine never finishes, a queued job follows.
        drv_job[0] = mk(42'h900, 42'hA00, 32'd9, -1, 0);
        drv_job[1] = mk(42'hB00, 42'hC00, 32'd2, 6, 0);
        drv_valid  = 4'b0011;
        tick();
        idle(100);

        // Stale finished flag for 3 cycles, then reset while a job runs.
        submit(0, mk(42'hD00, 42'hE00, 32'd1, 5, 0));
        idle(12);
        submit(1, mk(42'hD10, 42'hE10, 32'd1, 9, 3));
        idle(20);
        for (int i = 0; i < 3; i++) drv_job[i] = mk(AW'(32'hF00 + i), AW'(32'hF80 + i), 32'd4, 50, 0);
        drv_valid = 4'b0111;
        tick();
        idle(10);
        drv_rst = 1'b1;
        tick();
        tick();
        idle(5);

        // Random traffic with occasional resets.
        repeat (3000) begin
            drv_rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < N; i++) begin
                drv_job[i]   = rand_job();
                drv_valid[i] = ($urandom_range(0, 5) == 0);
            end
            tick();
        end

        guard = 0;
        while ((m_active || model_pending()) && guard < 3000) begin
            idle(1);
            guard++;
        end
        idle(2);
        check("final_busy", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
